cmp_share_sched: RTL and testbench

- Round-robin scheduler that shares one magnitude-compare datapath among NUM_REQ requesters.
- The datapath computes y = !(a < b), i.e. a >= b unsigned, and z = 1.
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- Operands are registered, one compare runs at a time, and the result is returned only to the granted requester.

---
 rtl/cmp_share_sched_if.sv | 28 ++
 rtl/cmp_share_sched.sv | 116 +++++++++++
 tb/tb_cmp_share_sched.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_share_sched_if.sv
// Request/response bundle between NUM_REQ requesters and the shared compare scheduler.
// The master side is the requester pool; the slave side is the scheduler.
interface cmp_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic                     rsp_y;
  logic                     rsp_z;
  logic                     busy;
  logic [CNT_W-1:0]         done_cnt;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_z, busy, done_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_z, busy, done_cnt
  );
endinterface

// File: rtl/cmp_share_sched.sv
// Round-robin share of one a>=b compare among NUM_REQ requesters; accept->rsp_valid is 2 cycles,
// 1 op per 3 cycles peak; a response is held until rsp_ready of the granted index, no accepts while busy.
module cmp_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  cmp_share_sched_if.slave io_bus
);
  localparam int               PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]   NR    = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RSP} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_gnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_y;
  logic               r_rsp_z;
  logic               r_busy;
  logic [CNT_W-1:0]   r_done_cnt;

  logic               w_gnt_vld;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [PTR_W:0]     w_sum;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [NUM_REQ-1:0] w_rsp_oh;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;

  // Scan from the farthest offset back to ptr so the closest valid index after ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= NR) begin
        w_sum = w_sum - NR;
      end
      if (io_bus.req_valid[w_sum[PTR_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_oh            = '0;
    w_gnt_oh[w_gnt_idx] = 1'b1;
    w_rsp_oh            = '0;
    w_rsp_oh[r_gnt]     = 1'b1;
  end

  assign w_a = io_bus.req_a[w_gnt_idx*WIDTH +: WIDTH];
  assign w_b = io_bus.req_b[w_gnt_idx*WIDTH +: WIDTH];

  assign io_bus.req_ready = (r_state == S_IDLE && w_gnt_vld) ? w_gnt_oh : '0;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_y     = r_rsp_y;
  assign io_bus.rsp_z     = r_rsp_z;
  assign io_bus.busy      = r_busy;
  assign io_bus.done_cnt  = r_done_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= '0;
      r_rsp_y     <= 1'b0;
      r_rsp_z     <= 1'b0;
      r_busy      <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_gnt   <= w_gnt_idx;
            r_busy  <= 1'b1;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_rsp_y     <= (r_a >= r_b);
          r_rsp_z     <= 1'b1;
          r_rsp_valid <= w_rsp_oh;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          // Only the granted index can complete the response.
          if (io_bus.rsp_ready[r_gnt]) begin
            r_rsp_valid <= '0;
            r_rsp_y     <= 1'b0;
            r_rsp_z     <= 1'b0;
            r_busy      <= 1'b0;
            r_done_cnt  <= r_done_cnt + CNT_W'(1);
            r_ptr       <= (r_gnt == LAST) ? '0 : r_gnt + PTR_W'(1);
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_share_sched.sv
// Directed bench for cmp_share_sched: one 16-bit-counter instance for protocol checks,
// one 4-bit-counter instance for counter wrap.
module tb_cmp_share_sched;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  cmp_share_sched_if #(.NUM_REQ(4), .WIDTH(8), .CNT_W(16)) bus ();
  cmp_share_sched_if #(.NUM_REQ(4), .WIDTH(8), .CNT_W(4))  bus2 ();

  cmp_share_sched #(.NUM_REQ(4), .WIDTH(8), .CNT_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  cmp_share_sched #(.NUM_REQ(4), .WIDTH(8), .CNT_W(4)) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
  endtask

  initial begin
    int idx;
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = '0;
    bus2.req_valid = '0;
    bus2.req_a     = '0;
    bus2.req_b     = '0;
    bus2.rsp_ready = '0;

    // Reset state
    repeat (2) @(posedge clk);
    smp();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_y", bus.rsp_y, 0);
    chk("rst_rsp_z", bus.rsp_z, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done_cnt", bus.done_cnt, 0);
    nxt();
    rst_n = 1'b1;

    // Single op from requester 1: 3 < 5
    set_op(1, 8'd3, 8'd5);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 4'b1111;
    smp();
    chk("t1_req_ready", bus.req_ready, 4'b0010);
    nxt();
    bus.req_valid = '0;
    smp();
    chk("t1_cmp_rsp_valid", bus.rsp_valid, 0);
    chk("t1_cmp_busy", bus.busy, 1);
    nxt();
    smp();
    chk("t1_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("t1_rsp_y", bus.rsp_y, 0);
    chk("t1_rsp_z", bus.rsp_z, 1);
    nxt();
    smp();
    chk("t1_done_cnt", bus.done_cnt, 1);
    chk("t1_idle_rsp_valid", bus.rsp_valid, 0);
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_rsp_z", bus.rsp_z, 0);

    // Plain reset pulse to bring ptr back to 0
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;

    // All four requesters continuously valid, a == b
    for (int i = 0; i < 4; i++) set_op(i, 8'hAA, 8'hAA);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("t2_grant", bus.req_ready, 32'(1 << (k % 4)));
      nxt();
      smp();
      chk("t2_cmp_req_ready", bus.req_ready, 0);
      nxt();
      smp();
      chk("t2_rsp_valid", bus.rsp_valid, 32'(1 << (k % 4)));
      chk("t2_rsp_y", bus.rsp_y, 1);
      chk("t2_rsp_req_ready", bus.req_ready, 0);
      nxt();
    end
    bus.req_valid = '0;
    smp();
    chk("t2_done_cnt", bus.done_cnt, 5);
    chk("t2_idle_req_ready", bus.req_ready, 0);
    nxt();

    // Requester 2: FF vs 00, response stalled 5 cycles while requester 0 waits
    set_op(2, 8'hFF, 8'h00);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 4'b0000;
    smp();
    chk("t3_req_ready", bus.req_ready, 4'b0100);
    nxt();
    bus.req_valid = 4'b0001;
    set_op(0, 8'h00, 8'h01);
    smp();
    chk("t3_cmp_req_ready", bus.req_ready, 0);
    nxt();
    bus.rsp_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("t3_hold_rsp_valid", bus.rsp_valid, 4'b0100);
      chk("t3_hold_rsp_y", bus.rsp_y, 1);
      chk("t3_hold_rsp_z", bus.rsp_z, 1);
      chk("t3_hold_busy", bus.busy, 1);
      chk("t3_hold_req_ready", bus.req_ready, 0);
      nxt();
    end
    bus.rsp_ready = 4'b1111;
    smp();
    chk("t3_last_rsp_valid", bus.rsp_valid, 4'b0100);
    nxt();

    // Requester 0 now granted (ptr=3 wraps to 0); a changes after accept
    smp();
    chk("t3_done_cnt", bus.done_cnt, 6);
    chk("t4_req_ready", bus.req_ready, 4'b0001);
    nxt();
    bus.req_a[7:0] = 8'hFF;
    bus.req_valid  = '0;
    nxt();
    smp();
    chk("t4_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("t4_rsp_y", bus.rsp_y, 0);
    nxt();
    smp();
    chk("t4_done_cnt", bus.done_cnt, 7);
    nxt();

    // Reset in CMP abandons the op and clears ptr
    set_op(1, 8'd5, 8'd3);
    bus.req_valid = 4'b0010;
    smp();
    chk("t5_req_ready", bus.req_ready, 4'b0010);
    nxt();
    bus.req_valid = '0;
    set_op(0, 8'd9, 8'd9);
    set_op(3, 8'd1, 8'd2);
    smp();
    chk("t5_cmp_busy", bus.busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_rsp_valid", bus.rsp_valid, 0);
    chk("t5_rst_rsp_z", bus.rsp_z, 0);
    chk("t5_rst_done_cnt", bus.done_cnt, 0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t5_no_rsp", bus.rsp_valid, 0);
      nxt();
    end
    bus.req_valid = 4'b1001;
    smp();
    chk("t5_grant0", bus.req_ready, 4'b0001);
    nxt();
    bus.req_valid = 4'b1000;
    nxt();
    smp();
    chk("t5_rsp_valid0", bus.rsp_valid, 4'b0001);
    chk("t5_rsp_y0", bus.rsp_y, 1);
    nxt();
    smp();
    chk("t5_grant3", bus.req_ready, 4'b1000);
    nxt();
    bus.req_valid = '0;
    nxt();
    smp();
    chk("t5_rsp_valid3", bus.rsp_valid, 4'b1000);
    chk("t5_rsp_y3", bus.rsp_y, 0);
    nxt();
    smp();
    chk("t5_done_cnt", bus.done_cnt, 2);
    nxt();

    // 4-bit counter instance: 17 ops wrap done_cnt to 1
    bus2.rsp_ready = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      idx = k % 4;
      bus2.req_a = '0;
      bus2.req_b = '0;
      bus2.req_a[idx*8 +: 8] = k[7:0];
      bus2.req_b[idx*8 +: 8] = 8'd8;
      bus2.req_valid = 4'(1 << idx);
      smp();
      chk("t6_req_ready", bus2.req_ready, 32'(1 << idx));
      nxt();
      bus2.req_valid = '0;
      nxt();
      smp();
      chk("t6_rsp_valid", bus2.rsp_valid, 32'(1 << idx));
      chk("t6_rsp_y", bus2.rsp_y, (k >= 8) ? 1 : 0);
      nxt();
    end
    smp();
    chk("t6_done_cnt_wrap", bus2.done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
